// File: rtl/pkt_rx_sink.sv
// Packet receive sink: validates framed packets and store-and-forwards good payloads.
// Define PKT_RX_SINK_STATS_EN to build the good/dropped packet counters.
module pkt_rx_sink #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned MAX_LEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_sop,
    input  logic        in_eop,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic [15:0] pkt_ok_cnt,
    output logic [15:0] pkt_err_cnt
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;
    typedef enum logic [1:0] {StIdle, StPayload, StCsum, StDrop} state_e;

    localparam ptr_t       OccLimit = ptr_t'(DEPTH - MAX_LEN);
    localparam logic [7:0] MaxLen8  = 8'(MAX_LEN);

    state_e     state_q, state_d;
    logic [7:0] len_q, len_d, csum_q, csum_d, cnt_q, cnt_d;
    ptr_t       wr_tent_q, wr_tent_d, wr_cmt_q, wr_cmt_d, rd_q, rd_d;
    logic       first_q, first_d;
    logic [8:0] mem [DEPTH];
    logic [8:0] rd_word;
    ptr_t       occ;
    logic       space_ok, in_beat, out_beat, hdr_bad, last_byte;
    logic       wr_en, eop_tag, take_hdr, ok_inc;
    logic [1:0] err_inc;

    assign occ       = wr_cmt_q - rd_q;
    assign space_ok  = occ <= OccLimit;
    assign in_beat   = in_valid & in_ready;
    assign out_beat  = out_valid & out_ready;
    assign hdr_bad   = (in_data == 8'd0) || (in_data > MaxLen8);
    assign last_byte = (cnt_q + 8'd1) == len_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            len_q     <= '0;
            csum_q    <= '0;
            cnt_q     <= '0;
            wr_tent_q <= '0;
            wr_cmt_q  <= '0;
            rd_q      <= '0;
            first_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            csum_q    <= csum_d;
            cnt_q     <= cnt_d;
            wr_tent_q <= wr_tent_d;
            wr_cmt_q  <= wr_cmt_d;
            rd_q      <= rd_d;
            first_q   <= first_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_tent_q[AW-1:0]] <= {eop_tag, in_data};
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        csum_d    = csum_q;
        cnt_d     = cnt_q;
        wr_tent_d = wr_tent_q;
        wr_cmt_d  = wr_cmt_q;
        wr_en     = 1'b0;
        eop_tag   = 1'b0;
        take_hdr  = 1'b0;
        ok_inc    = 1'b0;
        err_inc   = 2'd0;
        if (in_beat) begin
            unique case (state_q)
                StIdle: take_hdr = in_sop;
                StPayload: begin
                    if (in_sop) begin
                        wr_tent_d = wr_cmt_q;
                        err_inc   = 2'd1;
                        take_hdr  = 1'b1;
                    end else if (in_eop) begin
                        wr_tent_d = wr_cmt_q;
                        err_inc   = 2'd1;
                        state_d   = StIdle;
                    end else begin
                        wr_en     = 1'b1;
                        eop_tag   = last_byte;
                        wr_tent_d = wr_tent_q + 1'b1;
                        csum_d    = csum_q ^ in_data;
                        cnt_d     = cnt_q + 8'd1;
                        if (last_byte) state_d = StCsum;
                    end
                end
                StCsum: begin
                    if (in_sop) begin
                        wr_tent_d = wr_cmt_q;
                        err_inc   = 2'd1;
                        take_hdr  = 1'b1;
                    end else if (in_eop && in_data == csum_q) begin
                        wr_cmt_d = wr_tent_q;
                        ok_inc   = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        wr_tent_d = wr_cmt_q;
                        err_inc   = 2'd1;
                        state_d   = in_eop ? StIdle : StDrop;
                    end
                end
                StDrop: begin
                    if (in_sop) take_hdr = 1'b1;
                    else if (in_eop) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
            // Header rules apply both in IDLE and on a restarting in_sop beat.
            if (take_hdr) begin
                if (hdr_bad) begin
                    err_inc = err_inc + 2'd1;
                    state_d = in_eop ? StIdle : StDrop;
                end else begin
                    len_d   = in_data;
                    csum_d  = in_data;
                    cnt_d   = 8'd0;
                    state_d = StPayload;
                end
            end
        end
        rd_d    = out_beat ? rd_q + 1'b1 : rd_q;
        first_d = out_beat ? rd_word[8] : first_q;
    end

    always_comb begin
        rd_word   = mem[rd_q[AW-1:0]];
        in_ready  = ~rst & ((state_q != StIdle) | space_ok);
        out_valid = rd_q != wr_cmt_q;
        out_data  = out_valid ? rd_word[7:0] : 8'd0;
        out_eop   = out_valid & rd_word[8];
        out_sop   = out_valid & first_q;
    end

`ifdef PKT_RX_SINK_STATS_EN
    logic [15:0] ok_cnt_q, err_cnt_q;
    logic [16:0] err_sum;

    assign err_sum = {1'b0, err_cnt_q} + {15'd0, err_inc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ok_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            if (ok_inc && ok_cnt_q != 16'hFFFF) ok_cnt_q <= ok_cnt_q + 16'd1;
            err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    assign pkt_ok_cnt  = ok_cnt_q;
    assign pkt_err_cnt = err_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = ok_inc ^ (^err_inc);
    assign pkt_ok_cnt   = 16'd0;
    assign pkt_err_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_pkt_rx_sink.sv
// Randomized bench for pkt_rx_sink against a packet-level queue model, plus directed pins.
module tb_pkt_rx_sink;
    localparam int DEPTH   = 64;
    localparam int MAX_LEN = 32;
`ifdef PKT_RX_SINK_STATS_EN
    localparam int StatsEn = 1;
`else
    localparam int StatsEn = 0;
`endif
    localparam int MIdle = 0, MBody = 1, MSum = 2, MSkip = 3;

    logic clk = 1'b0, rst = 1'b1;
    logic in_valid, in_ready, in_sop, in_eop, out_valid, out_ready, out_sop, out_eop;
    logic [7:0] in_data, out_data;
    logic [15:0] pkt_ok_cnt, pkt_err_cnt;

    pkt_rx_sink #(.DEPTH(DEPTH), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
        .pkt_ok_cnt(pkt_ok_cnt), .pkt_err_cnt(pkt_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [7:0] d; logic sop; logic eop;} beat_t;

    beat_t      beats[$], exp_q[$], log_q[$];
    logic [7:0] cur[$], sent[$];
    int errors = 0, checks = 0, cyc = 0;
    int valid_pct = 100, ready_pct = 100;
    int m_mode = MIdle, m_len = 0, m_ok = 0, m_err = 0;
    int csum_acc_cyc = 0, first_valid_cyc = -1;
    bit ready_dipped = 0;

    function automatic beat_t mk(input logic [7:0] d, input logic sop, input logic eop);
        beat_t b;
        b.d = d; b.sop = sop; b.eop = eop;
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic void bump(inout int c);
        if (c < 65535) c++;
    endfunction

    function automatic bit model_ready();
        if (m_mode != MIdle) return 1'b1;
        return (DEPTH - exp_q.size()) >= MAX_LEN;
    endfunction

    // Packet-level view: collect payload, fold XOR at the checksum, publish whole packets.
    function automatic void model_in(input beat_t b);
        bit hdr = 1'b0;
        logic [7:0] x;
        case (m_mode)
            MIdle: hdr = b.sop;
            MBody: begin
                if (b.sop) begin bump(m_err); hdr = 1'b1; end
                else if (b.eop) begin bump(m_err); m_mode = MIdle; end
                else begin
                    cur.push_back(b.d);
                    if (cur.size() == m_len) m_mode = MSum;
                end
            end
            MSum: begin
                x = 8'(m_len);
                foreach (cur[i]) x ^= cur[i];
                if (b.sop) begin bump(m_err); hdr = 1'b1; end
                else if (b.eop && b.d == x) begin
                    foreach (cur[i]) exp_q.push_back(mk(cur[i], i == 0, i == cur.size() - 1));
                    bump(m_ok);
                    m_mode = MIdle;
                end else begin
                    bump(m_err);
                    m_mode = b.eop ? MIdle : MSkip;
                end
            end
            default: begin
                if (b.sop) hdr = 1'b1;
                else if (b.eop) m_mode = MIdle;
            end
        endcase
        if (hdr) begin
            cur.delete();
            if (b.d == 0 || int'(b.d) > MAX_LEN) begin
                bump(m_err);
                m_mode = b.eop ? MIdle : MSkip;
            end else begin
                m_len  = int'(b.d);
                m_mode = MBody;
            end
        end
    endfunction

    task automatic check_outputs();
        check("in_ready", in_ready, model_ready());
        check("out_valid", out_valid, exp_q.size() != 0);
        if (out_valid && exp_q.size() > 0) check("out_beat", {out_data, out_sop, out_eop}, exp_q[0]);
        check("ok_cnt", pkt_ok_cnt, StatsEn * m_ok);
        check("err_cnt", pkt_err_cnt, StatsEn * m_err);
    endtask

    task automatic tick();
        beat_t b;
        bit exp_rdy;
        @(negedge clk);
        if (!rst) check_outputs();
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (!in_ready) ready_dipped = 1'b1;
        b = mk(8'h00, 1'b0, 1'b0);
        if (beats.size() > 0 && $urandom_range(99) < valid_pct) begin
            b = beats[0];
            in_valid = 1'b1; in_data = b.d; in_sop = b.sop; in_eop = b.eop;
        end else begin
            in_valid = 1'b0; in_data = 8'($urandom); in_sop = 1'b0; in_eop = 1'b0;
        end
        out_ready = ($urandom_range(99) < ready_pct);
        exp_rdy = model_ready();
        if (out_ready && exp_q.size() > 0) begin
            log_q.push_back({out_data, out_sop, out_eop});
            void'(exp_q.pop_front());
        end
        if (in_valid && exp_rdy) begin
            if (b.eop) csum_acc_cyc = cyc;
            model_in(b);
            void'(beats.pop_front());
        end
        cyc++;
    endtask

    task automatic run(input int max);
        int n = 0;
        while ((beats.size() > 0 || exp_q.size() > 0) && n < max) begin
            tick();
            n++;
        end
        if (n >= max) check("run_bound", beats.size() + exp_q.size(), 0);
        repeat (2) tick();
    endtask

    task automatic clear_model();
        beats.delete(); exp_q.delete(); cur.delete(); log_q.delete(); sent.delete();
        m_mode = MIdle; m_ok = 0; m_err = 0; first_valid_cyc = -1; ready_dipped = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        clear_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // kind: 0 good, 1 bad checksum, 2 eop inside payload, 3 truncated (next sop aborts),
    // 4 checksum without eop followed by filler.
    task automatic push_pkt(input int len, input int kind);
        logic [7:0] p, cs;
        int cut;
        cs  = 8'(len);
        cut = (len > 1) ? int'($urandom_range(len - 1)) : 0;
        beats.push_back(mk(8'(len), 1'b1, 1'b0));
        for (int i = 0; i < len; i++) begin
            p = 8'($urandom);
            if (kind == 2 && i == cut) begin beats.push_back(mk(p, 1'b0, 1'b1)); return; end
            if (kind == 3 && i == cut) return;
            beats.push_back(mk(p, 1'b0, 1'b0));
            sent.push_back(p);
            cs ^= p;
        end
        if (kind == 1) beats.push_back(mk(cs ^ 8'h5A, 1'b0, 1'b1));
        else if (kind == 4) begin
            beats.push_back(mk(cs, 1'b0, 1'b0));
            beats.push_back(mk(8'h00, 1'b0, 1'b0));
            beats.push_back(mk(8'h01, 1'b0, 1'b1));
        end else beats.push_back(mk(cs, 1'b0, 1'b1));
    endtask

    task automatic push_bad_hdr();
        logic [7:0] d;
        int n;
        d = $urandom_range(1) ? 8'h00 : 8'($urandom_range(255, MAX_LEN + 1));
        n = $urandom_range(3);
        beats.push_back(mk(d, 1'b1, n == 0));
        for (int i = 1; i <= n; i++) beats.push_back(mk(8'($urandom), 1'b0, i == n));
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0; in_data = 8'h00; in_sop = 1'b0; in_eop = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_flags", {out_sop, out_eop}, 0);
        check("rst_cnts", {pkt_ok_cnt, pkt_err_cnt}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // Single good packet; checksum 03^AA^BB^CC = DE.
        do_reset();
        beats = '{mk(8'h03, 1, 0), mk(8'hAA, 0, 0), mk(8'hBB, 0, 0), mk(8'hCC, 0, 0),
                  mk(8'hDE, 0, 1)};
        run(100);
        check("s1_len", log_q.size(), 3);
        if (log_q.size() == 3) begin
            check("s1_b0", log_q[0], {8'hAA, 1'b1, 1'b0});
            check("s1_b1", log_q[1], {8'hBB, 1'b0, 1'b0});
            check("s1_b2", log_q[2], {8'hCC, 1'b0, 1'b1});
        end
        check("s1_latency", first_valid_cyc - csum_acc_cyc, 1);
        check("s1_ok", pkt_ok_cnt, StatsEn);

        // Bad checksum, then a one-byte good packet.
        do_reset();
        beats = '{mk(8'h02, 1, 0), mk(8'h11, 0, 0), mk(8'h22, 0, 0), mk(8'h00, 0, 1),
                  mk(8'h01, 1, 0), mk(8'h55, 0, 0), mk(8'h54, 0, 1)};
        run(100);
        check("s2_len", log_q.size(), 1);
        if (log_q.size() == 1) check("s2_b0", log_q[0], {8'h55, 1'b1, 1'b1});
        check("s2_cnts", {pkt_ok_cnt, pkt_err_cnt}, {16'(StatsEn), 16'(StatsEn)});

        // Illegal lengths 0 and 33.
        do_reset();
        beats = '{mk(8'h00, 1, 0), mk(8'hF1, 0, 0), mk(8'hF2, 0, 1),
                  mk(8'h21, 1, 0), mk(8'hF3, 0, 1)};
        run(100);
        check("s3_len", log_q.size(), 0);
        check("s3_ready_held", ready_dipped, 0);
        check("s3_err", pkt_err_cnt, 2 * StatsEn);

        // Backpressure: two full-size packets fill the FIFO.
        do_reset();
        ready_pct = 0;
        push_pkt(32, 0);
        push_pkt(32, 0);
        for (int n = 0; n < 500 && beats.size() > 0; n++) tick();
        check("s4_accepted", beats.size(), 0);
        repeat (2) tick();
        check("s4_full_ready", in_ready, 0);
        check("s4_full_valid", out_valid, 1);
        ready_pct = 100;
        run(500);
        check("s4_len", log_q.size(), 64);
        if (log_q.size() == 64 && sent.size() == 64)
            for (int i = 0; i < 64; i++) check("s4_order", log_q[i].d, sent[i]);
        check("s4_ready_back", in_ready, 1);

        // Abort by in_sop mid-payload.
        do_reset();
        beats = '{mk(8'h04, 1, 0), mk(8'h01, 0, 0), mk(8'h02, 0, 0),
                  mk(8'h01, 1, 0), mk(8'h7F, 0, 0), mk(8'h7E, 0, 1)};
        run(100);
        check("s5_len", log_q.size(), 1);
        if (log_q.size() == 1) check("s5_b0", log_q[0], {8'h7F, 1'b1, 1'b1});
        check("s5_cnts", {pkt_ok_cnt, pkt_err_cnt}, {16'(StatsEn), 16'(StatsEn)});

        // Reset in PAYLOAD with an unread committed packet.
        do_reset();
        ready_pct = 0;
        push_pkt(5, 0);
        beats.push_back(mk(8'h0A, 1, 0));
        for (int i = 0; i < 3; i++) beats.push_back(mk(8'($urandom), 0, 0));
        for (int n = 0; n < 100 && beats.size() > 0; n++) tick();
        check("s6_pre_valid", out_valid, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("s6_async_ready", in_ready, 0);
        check("s6_async_out", {out_valid, out_data, out_sop, out_eop}, 0);
        check("s6_async_cnts", {pkt_ok_cnt, pkt_err_cnt}, 0);
        in_valid = 1'b0;
        clear_model();
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("s6_post_valid", out_valid, 0);
        check("s6_post_ready", in_ready, 1);
        check("s6_post_cnts", {pkt_ok_cnt, pkt_err_cnt}, 0);

        // Randomized traffic in batches with varying flow control.
        do_reset();
        for (int batch = 0; batch < 4; batch++) begin
            valid_pct = (batch == 2) ? 100 : 80;
            ready_pct = (batch == 0) ? 20 : (batch == 1) ? 60 : (batch == 2) ? 100 : 90;
            for (int p = 0; p < 100; p++) begin
                int k;
                k = $urandom_range(11);
                if (k <= 5) push_pkt($urandom_range(MAX_LEN, 1), 0);
                else if (k <= 9) push_pkt($urandom_range(MAX_LEN, 1), k - 5);
                else if (k == 10) push_bad_hdr();
                else beats.push_back(mk(8'($urandom), 1'b0, 1'($urandom)));
            end
            run(20000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
